// File: rtl/pass_attempt_ctrl_pkg.sv
// Shared definitions for the password-attempt sequencer: state encodings,
// default password width and the lock-level saturating increment.
package pass_attempt_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_GRANT = 3'd2,
    S_DENY  = 3'd3,
    S_LOCK  = 3'd4
  } state_e;

  localparam int DEFAULT_PASS_W = 2;

  // Lock escalation level saturates at 3 (8x base lockout length).
  function automatic logic [1:0] lock_level_inc(input logic [1:0] lvl);
    return (lvl == 2'd3) ? 2'd3 : lvl + 2'd1;
  endfunction

endpackage

// File: rtl/pass_attempt_ctrl_cycle_timer.sv
// Loadable down-counter with a zero flag; stops at zero instead of wrapping.
// Shared by the grant and lockout phases, which never overlap.
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != {W{1'b0}})) begin
      count_d = count_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == {W{1'b0}});

endmodule

// File: rtl/pass_attempt_ctrl.sv
// Password attempt sequencer: latches an entry, checks the comparator result and
// issues grant / deny / lockout. Define LOCK_ESCALATE_EN for escalating lockouts.
module pass_attempt_ctrl
  import pass_attempt_ctrl_pkg::*;
#(
  parameter  int PASS_W       = DEFAULT_PASS_W,
  parameter  int MAX_TRIES    = 3,
  parameter  int GRANT_CYCLES = 8,
  parameter  int LOCK_CYCLES  = 16,
  localparam int TRIES_W      = $clog2(MAX_TRIES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PASS_W-1:0] pass_in,
  input  logic              pass_valid,
  input  logic              equal,
  output logic [PASS_W-1:0] pass_out,
  output logic              grant,
  output logic              deny,
  output logic              locked,
  output logic [TRIES_W-1:0] tries_left,
  output logic              busy
);

`ifdef LOCK_ESCALATE_EN
  localparam int MAX_LOCK = LOCK_CYCLES * 8;
`else
  localparam int MAX_LOCK = LOCK_CYCLES;
`endif
  localparam int TMAX    = (MAX_LOCK > GRANT_CYCLES) ? MAX_LOCK : GRANT_CYCLES;
  localparam int TIMER_W = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TIMER_W-1:0] GRANT_LOAD = TIMER_W'(GRANT_CYCLES - 1);
  localparam logic [TRIES_W-1:0] MAX_FAIL   = TRIES_W'(MAX_TRIES);

  state_e              state_q, state_d;
  logic [PASS_W-1:0]   pass_out_q, pass_out_d;
  logic [TRIES_W-1:0]  fail_cnt_q, fail_cnt_d;
  logic [TRIES_W-1:0]  tries_left_q, tries_left_d;
  logic                grant_q, grant_d;
  logic                deny_q, deny_d;
  logic                locked_q, locked_d;
  logic                busy_q, busy_d;
  logic                tmr_load;
  logic [TIMER_W-1:0]  tmr_val;
  logic                tmr_en;
  logic                tmr_zero;
  logic [TIMER_W-1:0]  lock_load;

`ifdef LOCK_ESCALATE_EN
  logic [1:0] lock_level_q, lock_level_d;
  // Lockout length doubles with each lock entry since the last grant.
  assign lock_load = TIMER_W'((LOCK_CYCLES << lock_level_q) - 1);
`else
  assign lock_load = TIMER_W'(LOCK_CYCLES - 1);
`endif

  assign tmr_en = (state_q == S_GRANT) || (state_q == S_LOCK);

  cycle_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d    = state_q;
    pass_out_d = pass_out_q;
    fail_cnt_d = fail_cnt_q;
    tmr_load   = 1'b0;
    tmr_val    = {TIMER_W{1'b0}};
`ifdef LOCK_ESCALATE_EN
    lock_level_d = lock_level_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pass_valid) begin
          pass_out_d = pass_in;
          state_d    = S_CHECK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CHECK: begin
        if (equal) begin
          fail_cnt_d = {TRIES_W{1'b0}};
          tmr_load   = 1'b1;
          tmr_val    = GRANT_LOAD;
          state_d    = S_GRANT;
`ifdef LOCK_ESCALATE_EN
          lock_level_d = 2'd0;
`endif
        end else if (({1'b0, fail_cnt_q} + {{TRIES_W{1'b0}}, 1'b1}) < {1'b0, MAX_FAIL}) begin
          fail_cnt_d = fail_cnt_q + {{(TRIES_W-1){1'b0}}, 1'b1};
          state_d    = S_DENY;
        end else begin
          fail_cnt_d = MAX_FAIL;
          tmr_load   = 1'b1;
          tmr_val    = lock_load;
          state_d    = S_LOCK;
`ifdef LOCK_ESCALATE_EN
          lock_level_d = lock_level_inc(lock_level_q);
`endif
        end
      end
      S_GRANT: begin
        if (tmr_zero) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_GRANT;
        end
      end
      S_DENY: begin
        state_d = S_IDLE;
      end
      S_LOCK: begin
        if (tmr_zero) begin
          fail_cnt_d = {TRIES_W{1'b0}};
          state_d    = S_IDLE;
        end else begin
          state_d = S_LOCK;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    grant_d      = (state_d == S_GRANT);
    deny_d       = (state_d == S_DENY);
    locked_d     = (state_d == S_LOCK);
    busy_d       = (state_d != S_IDLE);
    tries_left_d = MAX_FAIL - fail_cnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pass_out_q   <= {PASS_W{1'b0}};
      fail_cnt_q   <= {TRIES_W{1'b0}};
      tries_left_q <= MAX_FAIL;
      grant_q      <= 1'b0;
      deny_q       <= 1'b0;
      locked_q     <= 1'b0;
      busy_q       <= 1'b0;
`ifdef LOCK_ESCALATE_EN
      lock_level_q <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      pass_out_q   <= pass_out_d;
      fail_cnt_q   <= fail_cnt_d;
      tries_left_q <= tries_left_d;
      grant_q      <= grant_d;
      deny_q       <= deny_d;
      locked_q     <= locked_d;
      busy_q       <= busy_d;
`ifdef LOCK_ESCALATE_EN
      lock_level_q <= lock_level_d;
`endif
    end
  end

  assign pass_out   = pass_out_q;
  assign grant      = grant_q;
  assign deny       = deny_q;
  assign locked     = locked_q;
  assign tries_left = tries_left_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pass_attempt_ctrl.sv
// Self-checking bench for pass_attempt_ctrl with a fixed system key of 2'b10.
module tb_pass_attempt_ctrl;

  localparam logic [1:0] KEY = 2'b10;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pass_in;
  logic       pass_valid;
  logic       equal;
  logic [1:0] pass_out;
  logic       grant, deny, locked, busy;
  logic [1:0] tries_left;

  int checks = 0;
  int errors = 0;

  pass_attempt_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .pass_in    (pass_in),
    .pass_valid (pass_valid),
    .equal      (equal),
    .pass_out   (pass_out),
    .grant      (grant),
    .deny       (deny),
    .locked     (locked),
    .tries_left (tries_left),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Comparator model sitting downstream of pass_out.
  assign equal = (pass_out == KEY);

  typedef struct {
    logic       rst;
    logic       pv;
    logic [1:0] pin;
    logic       g, d, l, b;
    logic [1:0] t;
    logic [1:0] po;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic r, logic pv, logic [1:0] pin, logic g, logic d,
                              logic l, logic b, logic [1:0] t, logic [1:0] po);
    vec_t v;
    v.rst = r; v.pv = pv; v.pin = pin;
    v.g = g; v.d = d; v.l = l; v.b = b; v.t = t; v.po = po;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic pv, input logic [1:0] pin);
    rst = r; pass_valid = pv; pass_in = pin;
    @(posedge clk);
    #1;
  endtask

  task automatic do_lockout(output int n);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 2'b01);
      step(1'b0, 1'b0, 2'b00);
      if (k < 2) step(1'b0, 1'b0, 2'b00);
    end
    n = 0;
    while (locked && n < 300) begin
      n++;
      step(1'b0, 1'b0, 2'b00);
    end
  endtask

  task automatic do_grant(output int n);
    step(1'b0, 1'b1, KEY);
    step(1'b0, 1'b0, 2'b00);
    n = 0;
    while (grant && n < 100) begin
      n++;
      step(1'b0, 1'b0, 2'b00);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; pass_valid = 1'b0; pass_in = 2'b00;

    // rst pv pin g d l b tries pass_out
    add(1, 0, 2'b00, 0, 0, 0, 0, 2'd3, 2'b00);
    add(0, 0, 2'b00, 0, 0, 0, 0, 2'd3, 2'b00);
    // correct entry: grant for 8 cycles
    add(0, 1, 2'b10, 0, 0, 0, 1, 2'd3, 2'b10);
    for (int i = 0; i < 8; i++) add(0, 0, 2'b00, 1, 0, 0, 1, 2'd3, 2'b10);
    add(0, 0, 2'b00, 0, 0, 0, 0, 2'd3, 2'b10);
    // wrong then right
    add(0, 1, 2'b01, 0, 0, 0, 1, 2'd3, 2'b01);
    add(0, 0, 2'b00, 0, 1, 0, 1, 2'd2, 2'b01);
    add(0, 0, 2'b00, 0, 0, 0, 0, 2'd2, 2'b01);
    add(0, 1, 2'b10, 0, 0, 0, 1, 2'd2, 2'b10);
    for (int i = 0; i < 8; i++) add(0, 0, 2'b00, 1, 0, 0, 1, 2'd3, 2'b10);
    add(0, 0, 2'b00, 0, 0, 0, 0, 2'd3, 2'b10);
    // lockout after three wrong entries, strobes ignored while locked
    add(0, 1, 2'b01, 0, 0, 0, 1, 2'd3, 2'b01);
    add(0, 0, 2'b00, 0, 1, 0, 1, 2'd2, 2'b01);
    add(0, 0, 2'b00, 0, 0, 0, 0, 2'd2, 2'b01);
    add(0, 1, 2'b01, 0, 0, 0, 1, 2'd2, 2'b01);
    add(0, 0, 2'b00, 0, 1, 0, 1, 2'd1, 2'b01);
    add(0, 0, 2'b00, 0, 0, 0, 0, 2'd1, 2'b01);
    add(0, 1, 2'b01, 0, 0, 0, 1, 2'd1, 2'b01);
    for (int i = 0; i < 16; i++) add(0, (i >= 1) ? 1'b1 : 1'b0, 2'b10, 0, 0, 1, 1, 2'd0, 2'b01);
    add(0, 1, 2'b10, 0, 0, 0, 0, 2'd3, 2'b01);
    add(0, 0, 2'b00, 0, 0, 0, 0, 2'd3, 2'b01);
    // held strobe with a wrong password: one attempt per IDLE visit
    add(1, 0, 2'b00, 0, 0, 0, 0, 2'd3, 2'b00);
    add(0, 1, 2'b01, 0, 0, 0, 1, 2'd3, 2'b01);
    add(0, 1, 2'b01, 0, 1, 0, 1, 2'd2, 2'b01);
    add(0, 1, 2'b01, 0, 0, 0, 0, 2'd2, 2'b01);
    add(0, 1, 2'b01, 0, 0, 0, 1, 2'd2, 2'b01);
    add(0, 1, 2'b01, 0, 1, 0, 1, 2'd1, 2'b01);
    add(0, 0, 2'b00, 0, 0, 0, 0, 2'd1, 2'b01);
    add(1, 0, 2'b00, 0, 0, 0, 0, 2'd3, 2'b00);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].pv, tbl[i].pin);
      check("grant",      i, int'(grant),      int'(tbl[i].g));
      check("deny",       i, int'(deny),       int'(tbl[i].d));
      check("locked",     i, int'(locked),     int'(tbl[i].l));
      check("busy",       i, int'(busy),       int'(tbl[i].b));
      check("tries_left", i, int'(tries_left), int'(tbl[i].t));
      check("pass_out",   i, int'(pass_out),   int'(tbl[i].po));
    end

    // Reset in the fifth lockout cycle clears everything.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 2'b01);
      step(1'b0, 1'b0, 2'b00);
      if (k < 2) step(1'b0, 1'b0, 2'b00);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 2'b00);
    check("midlock_locked", 0, int'(locked), 1);
    step(1'b1, 1'b0, 2'b00);
    check("rst_locked", 0, int'(locked),     0);
    check("rst_busy",   0, int'(busy),       0);
    check("rst_tries",  0, int'(tries_left), 3);
    check("rst_pass",   0, int'(pass_out),   0);
    do_grant(n);
    check("grant_after_rst", 0, n, 8);

    // Lockout lengths: escalate only when the feature is built in.
    do_lockout(n);
    check("lock_len_1", 0, n, 16);
    check("tries_after_lock", 0, int'(tries_left), 3);
    do_lockout(n);
`ifdef LOCK_ESCALATE_EN
    check("lock_len_2", 0, n, 32);
`else
    check("lock_len_2", 0, n, 16);
`endif
    do_grant(n);
    check("grant_len", 0, n, 8);
    do_lockout(n);
    check("lock_len_3", 0, n, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
